// File: rtl/memory_access.sv
// MA stage: request/ack data-memory access with byte/half lane steering,
// stall generation, combinational EX forwarding and the MA/WB register.
module memory_access #(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int NB_CONTROL_MA     = 5,
  parameter int NB_CONTROL_WB     = 2,
  parameter int NB_CONTROL_MA_WB  = NB_CONTROL_MA + NB_CONTROL_WB
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clk_en,
  input  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb,
  input  logic [NB_DATA-1:0]           i_result,
  input  logic [NB_DATA-1:0]           i_w_data_mem,
  input  logic [NB_ADDR_REGISTERS-1:0] i_rd_num,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [NB_DATA-1:0]           o_mem_addr,
  output logic [NB_DATA-1:0]           o_mem_wdata,
  output logic [3:0]                   o_mem_wstrb,
  input  logic                         i_mem_ack,
  input  logic [NB_DATA-1:0]           i_mem_rdata,
  output logic                         o_stall,
  output logic                         o_addr_err,
  output logic [NB_DATA-1:0]           o_ex_rd_data,
  output logic [NB_ADDR_REGISTERS-1:0] o_ex_rd_num,
  output logic                         o_ex_ctl_rw,
  output logic [NB_CONTROL_WB-1:0]     o_control_wb,
  output logic [NB_DATA-1:0]           o_rd_data,
  output logic [NB_ADDR_REGISTERS-1:0] o_rd_num
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;

  logic [NB_CONTROL_MA-1:0] ctl_ma;
  logic [NB_CONTROL_WB-1:0] ctl_wb;
  logic mem_read, mem_write, uns, mem_to_reg, reg_write;
  logic [1:0] size;
  logic is_byte, is_half, is_word, mem_op, misaligned, start;

  assign ctl_ma = i_control_ma_wb[NB_CONTROL_MA_WB-1 -: NB_CONTROL_MA];
  assign ctl_wb = i_control_ma_wb[NB_CONTROL_WB-1:0];
  assign {mem_read, mem_write, size, uns} = ctl_ma;
  assign {mem_to_reg, reg_write} = ctl_wb;

  assign is_byte    = (size == 2'b00);
  assign is_half    = (size == 2'b01);
  assign is_word    = size[1];
  assign mem_op     = mem_read | mem_write;
  assign misaligned = (is_half & i_result[0]) | (is_word & (|i_result[1:0]));
  assign start      = (state == IDLE) & mem_op & ~misaligned;

  assign o_stall      = start | (state == ACCESS);
  assign o_ex_rd_data = i_result;
  assign o_ex_rd_num  = i_rd_num;
  assign o_ex_ctl_rw  = reg_write & ~mem_to_reg;

  // store lane steering
  logic [NB_DATA-1:0] wdata_nxt;
  logic [3:0]         wstrb_nxt;
  always_comb begin
    wdata_nxt = i_w_data_mem;
    wstrb_nxt = 4'b1111;
    if (is_byte) begin
      wdata_nxt = {(NB_DATA/8){i_w_data_mem[7:0]}};
      wstrb_nxt = 4'b0001 << i_result[1:0];
    end else if (is_half) begin
      wdata_nxt = {(NB_DATA/16){i_w_data_mem[15:0]}};
      wstrb_nxt = i_result[1] ? 4'b1100 : 4'b0011;
    end
    if (!mem_write) wstrb_nxt = 4'b0000;
  end

  // lane/size/sign captured at request time so the extract does not depend
  // on the frozen EX/MA register
  logic [1:0]         ld_lane, ld_size;
  logic               ld_uns;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_DATA-1:0] ld_ext, load_buf;
  always_comb begin
    byte_sel = i_mem_rdata[{ld_lane, 3'b000} +: 8];
    half_sel = i_mem_rdata[{ld_lane[1], 4'b0000} +: 16];
    if (ld_size[1])
      ld_ext = i_mem_rdata;
    else if (ld_size == 2'b01)
      ld_ext = {{(NB_DATA-16){~ld_uns & half_sel[15]}}, half_sel};
    else
      ld_ext = {{(NB_DATA-8){~ld_uns & byte_sel[7]}}, byte_sel};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && i_clk_en) state_nxt = ACCESS;
      ACCESS:  if (i_mem_ack) state_nxt = DONE;
      DONE:    if (i_clk_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_wstrb  <= 4'b0000;
      o_addr_err   <= 1'b0;
      o_control_wb <= '0;
      o_rd_data    <= '0;
      o_rd_num     <= '0;
      ld_lane      <= 2'b00;
      ld_size      <= 2'b00;
      ld_uns       <= 1'b0;
      load_buf     <= '0;
    end else begin
      state <= state_nxt;
      if (start && i_clk_en) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= mem_write;
        o_mem_addr  <= {i_result[NB_DATA-1:2], 2'b00};
        o_mem_wdata <= wdata_nxt;
        o_mem_wstrb <= wstrb_nxt;
        ld_lane     <= i_result[1:0];
        ld_size     <= size;
        ld_uns      <= uns;
      end
      if (state == ACCESS && i_mem_ack) begin
        o_mem_req <= 1'b0;
        load_buf  <= ld_ext;
      end
      if (i_clk_en && state == IDLE && mem_op && misaligned)
        o_addr_err <= 1'b1;
      if (i_clk_en) begin
        if (o_stall) begin
          o_control_wb <= '0;
        end else begin
          o_control_wb <= {mem_to_reg, reg_write & ~(mem_op & misaligned)};
          o_rd_data    <= mem_to_reg ? load_buf : i_result;
          o_rd_num     <= i_rd_num;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: stores, loads, lane handling, misalign,
// wait states with enable toggling, and reset during an access.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [6:0]  ctl = '0;
  logic [31:0] result = '0, wd = '0, rdata = '0;
  logic [4:0]  rd = '0;
  logic        ack = 1'b0;
  logic        req, we, stall, addr_err, ex_rw;
  logic [31:0] addr, wdata, ex_data, rd_data;
  logic [3:0]  wstrb;
  logic [4:0]  ex_num, rd_num;
  logic [1:0]  cwb;

  int checks = 0, errors = 0;

  localparam logic [6:0] LW  = 7'b1010011;
  localparam logic [6:0] SW  = 7'b0110000;
  localparam logic [6:0] LB  = 7'b1000011;
  localparam logic [6:0] LBU = 7'b1000111;
  localparam logic [6:0] LH  = 7'b1001011;
  localparam logic [6:0] SH  = 7'b0101000;
  localparam logic [6:0] ALU = 7'b0000001;

  memory_access dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_control_ma_wb(ctl),
    .i_result(result), .i_w_data_mem(wd), .i_rd_num(rd),
    .o_mem_req(req), .o_mem_we(we), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .o_mem_wstrb(wstrb), .i_mem_ack(ack), .i_mem_rdata(rdata),
    .o_stall(stall), .o_addr_err(addr_err), .o_ex_rd_data(ex_data),
    .o_ex_rd_num(ex_num), .o_ex_ctl_rw(ex_rw), .o_control_wb(cwb),
    .o_rd_data(rd_data), .o_rd_num(rd_num)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one memory instruction with ack after wait_cycles extra ACCESS
  // cycles; samples the request in the first ACCESS cycle and counts stalls.
  task automatic mem_txn(input logic [6:0] c, input logic [31:0] res, input logic [31:0] w,
                         input logic [4:0] r, input logic [31:0] rdv, input int wait_cycles,
                         output int stalls, output logic s_req, output logic s_we,
                         output logic [31:0] s_addr, output logic [31:0] s_wdata,
                         output logic [3:0] s_wstrb);
    ctl = c; result = res; wd = w; rd = r; ack = 1'b0; clk_en = 1'b1;
    stalls = 0;
    #1; if (stall) stalls++;
    tick;
    s_req = req; s_we = we; s_addr = addr; s_wdata = wdata; s_wstrb = wstrb;
    for (int i = 0; i < wait_cycles; i++) begin
      if (stall) stalls++;
      tick;
    end
    ack = 1'b1; rdata = rdv;
    if (stall) stalls++;
    tick;
    ack = 1'b0; rdata = 32'h0;
    if (stall) stalls++;
    tick;
    ctl = 7'b0; result = 32'h0; wd = 32'h0; rd = 5'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ctl = 7'b0;
    tick; tick;
    checks++; if ({req, we, wstrb, addr_err, cwb} !== 9'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {req, we, wstrb, addr_err, cwb}); end
    checks++; if ({addr, wdata, rd_data, rd_num} !== 101'b0) begin errors++; $display("FAIL reset_data got %h %h %h %h want 0", addr, wdata, rd_data, rd_num); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_word_store_load;
    int st; logic q, e; logic [31:0] a, d; logic [3:0] s;
    mem_txn(SW, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 0, st, q, e, a, d, s);
    checks++; if (st !== 2) begin errors++; $display("FAIL sw_stalls got %0d want 2", st); end
    checks++; if ({q, e, s} !== 6'b111111) begin errors++; $display("FAIL sw_req got %b want 111111", {q, e, s}); end
    checks++; if (a !== 32'h10 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_addr_data got %h %h want 00000010 deadbeef", a, d); end
    mem_txn(LW, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 0, st, q, e, a, d, s);
    checks++; if (st !== 2) begin errors++; $display("FAIL lw_stalls got %0d want 2", st); end
    checks++; if ({q, e, s} !== 6'b100000) begin errors++; $display("FAIL lw_req got %b want 100000", {q, e, s}); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", rd_data); end
    checks++; if (rd_num !== 5'd5 || cwb !== 2'b11) begin errors++; $display("FAIL lw_wb got %0d %b want 5 11", rd_num, cwb); end
  endtask

  task automatic test_load_extend;
    int st; logic q, e; logic [31:0] a, d; logic [3:0] s;
    mem_txn(LB, 32'h13, 32'h0, 5'd6, 32'h80FFFF7F, 0, st, q, e, a, d, s);
    checks++; if (rd_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", rd_data); end
    checks++; if (a !== 32'h10) begin errors++; $display("FAIL lb_addr got %h want 00000010", a); end
    mem_txn(LBU, 32'h13, 32'h0, 5'd6, 32'h80FFFF7F, 0, st, q, e, a, d, s);
    checks++; if (rd_data !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", rd_data); end
    mem_txn(LB, 32'h10, 32'h0, 5'd6, 32'h80FFFF7F, 0, st, q, e, a, d, s);
    checks++; if (rd_data !== 32'h0000007F) begin errors++; $display("FAIL lb_lane0 got %h want 0000007f", rd_data); end
    mem_txn(LH, 32'h12, 32'h0, 5'd6, 32'h80FFFF7F, 0, st, q, e, a, d, s);
    checks++; if (rd_data !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_signed got %h want ffff80ff", rd_data); end
  endtask

  task automatic test_store_half;
    int st; logic q, e; logic [31:0] a, d; logic [3:0] s;
    mem_txn(SH, 32'h12, 32'h0000ABCD, 5'd0, 32'h0, 0, st, q, e, a, d, s);
    checks++; if (s !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b want 1100", s); end
    checks++; if (d !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", d); end
    checks++; if (a !== 32'h10) begin errors++; $display("FAIL sh_addr got %h want 00000010", a); end
  endtask

  task automatic test_misaligned;
    ctl = LW; result = 32'h11; rd = 5'd7; clk_en = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b want 0", stall); end
    tick;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mis_req got %b want 0", req); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", addr_err); end
    checks++; if (cwb !== 2'b10) begin errors++; $display("FAIL mis_cwb got %b want 10", cwb); end
    ctl = ALU; result = 32'h55; rd = 5'd3;
    tick;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b want 1", addr_err); end
    checks++; if (cwb !== 2'b01 || rd_data !== 32'h55 || rd_num !== 5'd3) begin errors++; $display("FAIL alu_wb got %b %h %0d want 01 00000055 3", cwb, rd_data, rd_num); end
  endtask

  task automatic test_wait_clk_en;
    int st;
    ctl = ALU; result = 32'h111; rd = 5'd2; clk_en = 1'b1;
    #1;
    checks++; if (ex_data !== 32'h111 || ex_num !== 5'd2 || ex_rw !== 1'b1) begin errors++; $display("FAIL fwd_alu got %h %0d %b want 00000111 2 1", ex_data, ex_num, ex_rw); end
    tick;
    checks++; if (rd_data !== 32'h111) begin errors++; $display("FAIL pre_alu got %h want 00000111", rd_data); end
    ctl = LW; result = 32'h20; wd = 32'h5A5A5A5A; rd = 5'd9; ack = 1'b0; st = 0;
    #1; if (stall) st++;
    tick;
    checks++; if (cwb !== 2'b00 || rd_data !== 32'h111) begin errors++; $display("FAIL bubble got %b %h want 00 00000111", cwb, rd_data); end
    checks++; if (ex_rw !== 1'b0 || ex_data !== 32'h20) begin errors++; $display("FAIL fwd_stall got %b %h want 0 00000020", ex_rw, ex_data); end
    wd = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      clk_en = i[0];
      if (i == 3) begin ack = 1'b1; rdata = 32'hCAFEF00D; end
      #1; if (stall) st++;
      checks++; if (req !== 1'b1 || addr !== 32'h20 || wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL hold_%0d got %b %h %h want 1 00000020 5a5a5a5a", i, req, addr, wdata); end
      tick;
    end
    ack = 1'b0; rdata = 32'h0; clk_en = 1'b0;
    #1; if (stall) st++;
    tick;
    checks++; if (req !== 1'b0 || rd_data !== 32'h111 || cwb !== 2'b00) begin errors++; $display("FAIL done_hold got %b %h %b want 0 00000111 00", req, rd_data, cwb); end
    clk_en = 1'b1; wd = 32'h5A5A5A5A;
    #1; if (stall) st++;
    tick;
    checks++; if (st !== 5) begin errors++; $display("FAIL wait_stalls got %0d want 5", st); end
    checks++; if (rd_data !== 32'hCAFEF00D || rd_num !== 5'd9 || cwb !== 2'b11) begin errors++; $display("FAIL wait_wb got %h %0d %b want cafef00d 9 11", rd_data, rd_num, cwb); end
    ctl = 7'b0; result = 32'h0; wd = 32'h0; rd = 5'd0;
  endtask

  task automatic test_reset_mid_access;
    ctl = ALU; result = 32'h77; rd = 5'd4; clk_en = 1'b1;
    tick;
    ctl = SW; result = 32'h30; wd = 32'h99;
    tick;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL mid_req got %b want 1", req); end
    ctl = 7'b0; result = 32'h0; wd = 32'h0; rd = 5'd0; rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if ({req, we, wstrb, addr_err, cwb, stall} !== 10'b0) begin errors++; $display("FAIL rst_mid_ctrl got %b want 0", {req, we, wstrb, addr_err, cwb, stall}); end
    checks++; if ({addr, wdata, rd_data, rd_num} !== 101'b0) begin errors++; $display("FAIL rst_mid_data got %h %h %h %h want 0", addr, wdata, rd_data, rd_num); end
    ack = 1'b1; rdata = 32'h12345678;
    tick;
    ack = 1'b0;
    tick;
    checks++; if (req !== 1'b0 || stall !== 1'b0 || cwb !== 2'b00 || rd_data !== 32'h0) begin errors++; $display("FAIL late_ack got %b %b %b %h want 0 0 00 0", req, stall, cwb, rd_data); end
  endtask

  initial begin
    test_reset;
    test_word_store_load;
    test_load_extend;
    test_store_half;
    test_misaligned;
    test_wait_clk_en;
    test_reset_mid_access;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
